// File: rtl/common_sw_to_fw_pkg.sv
// common_sw_to_fw_pkg: shared op-codes, command-word layout and status bit indices
package common_sw_to_fw_pkg;
  localparam int CMD_W        = 32;
  localparam int DATA_W       = 32;
  localparam int DEV_ID_LSB   = 28;
  localparam int OP_CODE_LSB  = 24;
  localparam int PAYLOAD_LSB  = 0;
  localparam int PAYLOAD_W    = 24;
  localparam int NUM_OP_CODES = 11;
  localparam int ERR_DEV_BIT  = 0;
  localparam int ERR_OP_BIT   = 1;
  localparam int ERR_STRB_BIT = 2;
  localparam int ERR_CNT_LSB  = 3;
  localparam int ERR_CNT_W    = 5;
  typedef enum logic [3:0] {
    OP_W_RESET        = 4'd0,
    OP_W_CFG_STATIC_0 = 4'd1,
    OP_R_CFG_STATIC_0 = 4'd2,
    OP_W_CFG_ARRAY_0  = 4'd3,
    OP_R_CFG_ARRAY_0  = 4'd4,
    OP_W_CFG_ARRAY_1  = 4'd5,
    OP_R_CFG_ARRAY_1  = 4'd6,
    OP_R_DATA_ARRAY_0 = 4'd7,
    OP_R_DATA_ARRAY_1 = 4'd8,
    OP_R_STATUS       = 4'd9,
    OP_W_EXECUTE      = 4'd10
  } op_code_e;
endpackage

// File: rtl/common_sw_to_fw_rd_mux.sv
// common_sw_to_fw_rd_mux: registered one-hot NUM_FW:1 mux of 32-bit IP words
module common_sw_to_fw_rd_mux
  import common_sw_to_fw_pkg::*;
#(
  parameter int NUM_FW = 15
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_FW-1:0]        sel,
  input  logic [DATA_W*NUM_FW-1:0] bus,
  output logic [DATA_W-1:0]        dout
);
  logic [DATA_W-1:0] mux;
  // sel is one-hot or zero, so an AND-OR tree yields 0 when no IP is enabled
  always_comb begin
    mux = '0;
    for (int i = 0; i < NUM_FW; i++) mux = mux | (bus[DATA_W*i +: DATA_W] & {DATA_W{sel[i]}});
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) dout <= '0;
    else dout <= mux;
endmodule

// File: rtl/common_sw_to_fw_side.sv
// common_sw_to_fw_side: SW command decoder to per-IP enables/strobes plus read-back mux
// Optional SW_TO_FW_WR_COUNT_EN exposes a legal-command counter on sw_err_status[7:3].
module common_sw_to_fw_side
  import common_sw_to_fw_pkg::*;
#(
  parameter int NUM_FW    = 15,
  parameter int OP_CODE_W = 4,
  parameter int DEV_ID_W  = 4
) (
  input  logic                     fw_clk,
  input  logic                     fw_rst_n,
  input  logic [CMD_W-1:0]         sw_write32_0,
  input  logic                     sw_write32_0_wr,
  output logic [NUM_FW-1:0]        fw_dev_id_enable,
  output logic                     fw_op_code_w_reset,
  output logic                     fw_op_code_w_cfg_static_0,
  output logic                     fw_op_code_r_cfg_static_0,
  output logic                     fw_op_code_w_cfg_array_0,
  output logic                     fw_op_code_r_cfg_array_0,
  output logic                     fw_op_code_w_cfg_array_1,
  output logic                     fw_op_code_r_cfg_array_1,
  output logic                     fw_op_code_r_data_array_0,
  output logic                     fw_op_code_r_data_array_1,
  output logic                     fw_op_code_r_status,
  output logic                     fw_op_code_w_execute,
  output logic [PAYLOAD_W-1:0]     sw_write24_0,
  input  logic [DATA_W*NUM_FW-1:0] fw_read_data32_bus,
  input  logic [DATA_W*NUM_FW-1:0] fw_read_status32_bus,
  output logic [DATA_W-1:0]        sw_read32_0,
  output logic [DATA_W-1:0]        sw_read32_1,
  output logic [7:0]               sw_err_status
);
  logic [DEV_ID_W-1:0]     dev_id;
  logic [OP_CODE_W-1:0]    op_code;
  logic                    dev_ok, op_ok, is_rst, wr_ok;
  logic [NUM_OP_CODES-1:0] strb_q;
  logic [1:0]              sticky_q;
  logic [ERR_CNT_W-1:0]    cnt_view;
  assign dev_id  = sw_write32_0[DEV_ID_LSB +: DEV_ID_W];
  assign op_code = sw_write32_0[OP_CODE_LSB +: OP_CODE_W];
  assign dev_ok  = (dev_id != '0) && (32'(dev_id) <= NUM_FW);
  assign op_ok   = 32'(op_code) < NUM_OP_CODES;
  assign is_rst  = op_code == OP_CODE_W'(OP_W_RESET);
  assign wr_ok   = sw_write32_0_wr && dev_ok && op_ok;
  // Enable and payload follow any write with a legal dev_id, even if its op is illegal
  always_ff @(posedge fw_clk or negedge fw_rst_n)
    if (!fw_rst_n) begin
      fw_dev_id_enable <= '0;
      sw_write24_0     <= '0;
      strb_q           <= '0;
      sticky_q         <= '0;
    end else begin
      strb_q <= '0;
      if (sw_write32_0_wr && !dev_ok) sticky_q[ERR_DEV_BIT] <= 1'b1;
      if (sw_write32_0_wr && dev_ok) begin
        fw_dev_id_enable <= NUM_FW'(1) << (dev_id - DEV_ID_W'(1));
        sw_write24_0     <= sw_write32_0[PAYLOAD_LSB +: PAYLOAD_W];
        if (!op_ok) sticky_q[ERR_OP_BIT] <= 1'b1;
      end
      if (wr_ok) strb_q <= NUM_OP_CODES'(1) << op_code;
      if (wr_ok && is_rst) sticky_q <= '0;
    end
  assign {fw_op_code_w_execute, fw_op_code_r_status, fw_op_code_r_data_array_1,
          fw_op_code_r_data_array_0, fw_op_code_r_cfg_array_1, fw_op_code_w_cfg_array_1,
          fw_op_code_r_cfg_array_0, fw_op_code_w_cfg_array_0, fw_op_code_r_cfg_static_0,
          fw_op_code_w_cfg_static_0, fw_op_code_w_reset} = strb_q;
`ifdef SW_TO_FW_WR_COUNT_EN
  logic [7:0] cnt_q;
  always_ff @(posedge fw_clk or negedge fw_rst_n)
    if (!fw_rst_n) cnt_q <= '0;
    else if (wr_ok) cnt_q <= is_rst ? '0 : cnt_q + 8'd1;
  assign cnt_view = cnt_q[ERR_CNT_W-1:0];
`else
  assign cnt_view = '0;
`endif
  assign sw_err_status = {cnt_view, |strb_q, sticky_q};
  common_sw_to_fw_rd_mux #(.NUM_FW(NUM_FW)) u_rd_data (
    .clk(fw_clk), .rst_n(fw_rst_n), .sel(fw_dev_id_enable),
    .bus(fw_read_data32_bus), .dout(sw_read32_0)
  );
  common_sw_to_fw_rd_mux #(.NUM_FW(NUM_FW)) u_rd_status (
    .clk(fw_clk), .rst_n(fw_rst_n), .sel(fw_dev_id_enable),
    .bus(fw_read_status32_bus), .dout(sw_read32_1)
  );
endmodule
